// File: rtl/hack_writeback.sv
// hack_writeback: Hack CPU commit stage (A/D/PC update, dest-M memory write, jumps); optional WB_HALT_DETECT_EN.
module hack_writeback #(
  parameter int PC_W = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     instr,
  input  logic [15:0]     alu_out,
  input  logic            zr,
  input  logic            ng,
  output logic            mem_we,
  output logic [14:0]     mem_addr,
  output logic [15:0]     mem_wdata,
  input  logic            mem_ready,
  output logic [15:0]     a_reg,
  output logic [15:0]     d_reg,
  output logic [PC_W-1:0] pc,
  output logic            retired,
  output logic            halted
);
  typedef enum logic {IDLE, MEMWAIT} state_t;
  state_t state, state_nx;
  logic [15:0] l_instr, l_alu, c_instr, c_alu;
  logic [14:0] l_olda, c_olda;
  logic l_zr, l_ng, c_zr, c_ng;
  logic accept, go_mem, commit, take;
  assign accept = in_valid && in_ready;
  assign go_mem = accept && instr[15] && instr[3];
  // In IDLE the live inputs commit directly; MEMWAIT replays the latched copy.
  assign c_instr = state == IDLE ? instr : l_instr;
  assign c_alu = state == IDLE ? alu_out : l_alu;
  assign c_zr = state == IDLE ? zr : l_zr;
  assign c_ng = state == IDLE ? ng : l_ng;
  assign c_olda = state == IDLE ? a_reg[14:0] : l_olda;
  assign commit = state == IDLE ? accept && !go_mem : mem_ready;
  assign take = c_instr[15] && ((c_instr[2] && c_ng) || (c_instr[1] && c_zr) || (c_instr[0] && !c_zr && !c_ng));
  assign in_ready = state == IDLE && !halted;
  assign mem_we = state == MEMWAIT;
  assign mem_addr = l_olda;
  assign mem_wdata = l_alu;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (go_mem ? MEMWAIT : IDLE) : (mem_ready ? IDLE : MEMWAIT);
  end
`ifndef WB_HALT_DETECT_EN
  assign halted = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      d_reg <= '0;
      pc <= RESET_PC;
      retired <= 1'b0;
      l_instr <= '0;
      l_alu <= '0;
      l_olda <= '0;
      l_zr <= 1'b0;
      l_ng <= 1'b0;
`ifdef WB_HALT_DETECT_EN
      halted <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      retired <= commit;
      if (accept) begin
        l_instr <= instr;
        l_alu <= alu_out;
        l_olda <= a_reg[14:0];
        l_zr <= zr;
        l_ng <= ng;
      end
      if (commit) begin
        if (!c_instr[15]) a_reg <= {1'b0, c_instr[14:0]};
        else if (c_instr[5]) a_reg <= c_alu;
        if (c_instr[15] && c_instr[4]) d_reg <= c_alu;
        pc <= take ? c_olda[PC_W-1:0] : pc + PC_W'(1);
`ifdef WB_HALT_DETECT_EN
        if (take && c_olda[PC_W-1:0] == pc) halted <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_hack_writeback.sv
// tb_hack_writeback: directed vectors with a commit scoreboard checked by a retire monitor.
module tb_hack_writeback;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, zr = 1'b0, ng = 1'b0, mem_ready = 1'b0;
  logic in_ready, mem_we, retired, halted;
  logic [15:0] instr = '0, alu_out = '0, mem_wdata, a_reg, d_reg;
  logic [14:0] mem_addr, pc;
  logic [46:0] q[$];
  int n_vec = 0, n_err = 0, we_cnt;

  hack_writeback dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .alu_out(alu_out), .zr(zr), .ng(ng), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .a_reg(a_reg), .d_reg(d_reg),
    .pc(pc), .retired(retired), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && retired) begin
      if (q.size() == 0) chk("unexpected_retire", 48'(pc), 48'h0);
      else chk("commit{a,d,pc}", 48'({a_reg, d_reg, pc}), 48'(q.pop_front()));
    end
  end

  task automatic issue(input logic [15:0] i, input logic [15:0] alu, input logic z, input logic n,
                       input logic [15:0] ea, input logic [15:0] ed, input logic [14:0] ep, input bit push);
    @(negedge clk);
    instr = i; alu_out = alu; zr = z; ng = n; in_valid = 1'b1;
    if (push) q.push_back({ea, ed, ep});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_a", 48'(a_reg), 48'h0);
    chk("rst_d", 48'(d_reg), 48'h0);
    chk("rst_pc", 48'(pc), 48'h0);
    chk("rst_we", 48'(mem_we), 48'h0);
    chk("rst_retired", 48'(retired), 48'h0);
    chk("rst_halted", 48'(halted), 48'h0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 48'(in_ready), 48'h1);
    issue(16'h0005, 16'h0, 0, 0, 16'h0005, 16'h0000, 15'd1, 1);
    chk("a_instr_no_we", 48'(mem_we), 48'h0);
    issue(16'hEC10, 16'h0005, 0, 0, 16'h0005, 16'h0005, 15'd2, 1);
    issue(16'h0020, 16'h0, 0, 0, 16'h0020, 16'h0005, 15'd3, 1);
    issue(16'hE008, 16'h1234, 0, 0, 16'h0020, 16'h0005, 15'd4, 1);
    we_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_ready = (k == 3);
      we_cnt += int'(mem_we);
      chk("mw_addr", 48'(mem_addr), 48'h0020);
      chk("mw_data", 48'(mem_wdata), 48'h1234);
      chk("mw_in_ready", 48'(in_ready), 48'h0);
      chk("mw_no_retire", 48'(retired), 48'h0);
      chk("mw_pc_hold", 48'(pc), 48'd3);
    end
    @(posedge clk);
    #1 mem_ready = 1'b0;
    chk("mw_we_cycles", 48'(we_cnt), 48'd4);
    @(negedge clk);
    chk("mw_we_drop", 48'(mem_we), 48'h0);
    issue(16'h0010, 16'h0, 0, 0, 16'h0010, 16'h0005, 15'h0005, 1);
    issue(16'hE022, 16'h0099, 1, 0, 16'h0099, 16'h0005, 15'h0010, 1);
    issue(16'h0010, 16'h0, 0, 0, 16'h0010, 16'h0005, 15'h0011, 1);
    issue(16'hE022, 16'h0099, 0, 0, 16'h0099, 16'h0005, 15'h0012, 1);
    issue(16'h0030, 16'h0, 0, 0, 16'h0030, 16'h0005, 15'h0013, 1);
    issue(16'hE004, 16'hFFFF, 0, 1, 16'h0030, 16'h0005, 15'h0030, 1);
    issue(16'h7FFF, 16'h0, 0, 0, 16'h7FFF, 16'h0005, 15'h0031, 1);
    issue(16'hE007, 16'h0000, 1, 0, 16'h7FFF, 16'h0005, 15'h7FFF, 1);
    issue(16'h0001, 16'h0, 0, 0, 16'h0001, 16'h0005, 15'h0000, 1);
    issue(16'h0040, 16'h0, 0, 0, 16'h0040, 16'h0005, 15'h0001, 1);
    issue(16'hE008, 16'h5555, 0, 0, 16'h0, 16'h0, 15'h0, 0);
    @(negedge clk);
    chk("abort_we_before", 48'(mem_we), 48'h1);
    #2 rst_n = 1'b0;
    #1 chk("abort_we_async", 48'(mem_we), 48'h0);
    chk("abort_a", 48'(a_reg), 48'h0);
    chk("abort_d", 48'(d_reg), 48'h0);
    chk("abort_pc", 48'(pc), 48'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_in_ready", 48'(in_ready), 48'h1);
    issue(16'h0003, 16'h0, 0, 0, 16'h0003, 16'h0000, 15'd1, 1);
    issue(16'h0003, 16'h0, 0, 0, 16'h0003, 16'h0000, 15'd2, 1);
    issue(16'h0003, 16'h0, 0, 0, 16'h0003, 16'h0000, 15'd3, 1);
    issue(16'hEA87, 16'h0000, 1, 0, 16'h0003, 16'h0000, 15'd3, 1);
    @(negedge clk);
`ifdef WB_HALT_DETECT_EN
    chk("halt_set", 48'(halted), 48'h1);
    instr = 16'h0007; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("halt_in_ready", 48'(in_ready), 48'h0);
      chk("halt_sticky", 48'(halted), 48'h1);
    end
    in_valid = 1'b0;
`else
    chk("no_halt", 48'(halted), 48'h0);
    chk("no_halt_ready", 48'(in_ready), 48'h1);
    issue(16'hEA87, 16'h0000, 1, 0, 16'h0003, 16'h0000, 15'd3, 1);
`endif
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 48'(q.size()), 48'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hack_writeback.md
Name: hack_writeback

Overview:
- Writeback/commit stage directly downstream of the Hack 16-bit ALU.
- Accepts one decoded Hack instruction plus the ALU result and flags (out, zr, ng).
- Commits to the A and D registers, issues the data-memory write for dest=M, and evaluates the jump condition to update the PC.
- Multi-cycle only when a memory write stalls on mem_ready.

Parameters:
- PC_W, 15, program counter width; PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction and ALU result are presented.
- in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
- instr  input  16  Hack instruction: bit15 C/A select, bits5..3 dest A,D,M, bits2..0 jump lt,eq,gt.
- alu_out  input  16  ALU result for this instruction.
- zr  input  1  ALU zero flag.
- ng  input  1  ALU negative flag.
- mem_we  output  1  data-memory write request.
- mem_addr  output  15  write address (A[14:0] before commit).
- mem_wdata  output  16  write data (latched alu_out).
- mem_ready  input  1  memory accepts the write this cycle.
- a_reg  output  16  A register.
- d_reg  output  16  D register.
- pc  output  PC_W  program counter.
- retired  output  1  one-cycle pulse per committed instruction.
- halted  output  1  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0): a_reg=0, d_reg=0, pc=RESET_PC, mem_we=0, retired=0, halted=0, state=IDLE, in_ready=1 after reset release.
- States: IDLE, MEMWAIT.
- IDLE: in_ready=1. On transfer, latch instr, alu_out, zr, ng, and old A.
  - A-instr (bit15=0): next edge a_reg={1'b0,instr[14:0]}, pc=pc+1, retired=1. Stay in IDLE.
  - C-instr with dest M=0: next edge commit, retired=1. Stay in IDLE.
  - C-instr with dest M=1: go to MEMWAIT. No register or PC change yet.
- MEMWAIT: in_ready=0. mem_we=1, mem_addr=oldA[14:0], mem_wdata=latched alu_out, all held stable. When mem_ready=1 on an edge: commit, retired=1, mem_we=0 next cycle, return to IDLE.
- Commit (C-instr):
  - If dest A: a_reg=alu_out. If dest D: d_reg=alu_out.
  - take = (j[2]&ng) | (j[1]&zr) | (j[0]&~zr&~ng).
  - pc = take ? oldA[PC_W-1:0] : pc+1.
- The jump target is always A before this instruction's dest-A update, including the case dest=A plus jump.
- Latency: one cycle from accept to commit. With a memory write: 1 + number of cycles mem_ready is low.
- PC wraps: 2^PC_W-1 +1 -> 0.
- mem_ready while mem_we=0 is ignored. in_valid while in_ready=0 is not accepted, and upstream holds it.
- Reset mid-MEMWAIT aborts the write: mem_we drops to 0 immediately (asynchronously), and no commit occurs.

Optional Feature:
- Macro WB_HALT_DETECT_EN.
- Defined:
  - A committed C-instr with take=1 and oldA[PC_W-1:0]==pc (jump-to-self) sets halted=1.
  - While halted=1: in_ready=0, no further commits, halted sticky until reset.
- Undefined: halted is tied to 0, and jump-to-self loops normally.

Test Plan:
- Reset, then A-instr 0x0005 -> a_reg=0x0005, pc=1, retired pulses once, mem_we never asserted.
- A=0x0005, C-instr dest=D (0xEC10), alu_out=0x0005 -> d_reg=0x0005, pc advances by 1, one-cycle latency.
- A=0x0020, C-instr dest=M, alu_out=0x1234, mem_ready low 3 cycles -> mem_we high 4 cycles with addr 0x0020, data 0x1234. in_ready low throughout. pc/retired update only on the mem_ready edge.
- A=0x0010, C-instr jump=JEQ (j=010), dest=A, alu_out=0x0099, zr=1 -> pc=0x0010 (old A), a_reg=0x0099. Same with zr=0, ng=0 -> pc=pc+1.
- pc=0x7FFF, non-jumping instruction -> pc=0x0000.
- Assert rst_n low during MEMWAIT -> mem_we=0 immediately. Registers=0, pc=RESET_PC. After release, in_ready=1.
- With WB_HALT_DETECT_EN: pc=3, A=3, unconditional jump 0;JMP -> halted=1, in_ready=0 until reset.
